// File: rtl/demux_stream_sched.sv
// 1x4 stream demux controller: steers each accepted word to one channel (addressed or
// round-robin over enabled channels) through a registered single-entry output stage.
module demux_stream_sched #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic [3:0]        en_mask,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_dest,
    output logic              in_ready,
    output logic [3:0]        out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic [3:0]        out_ready,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic              busy
);

    localparam int unsigned NCH   = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   buf_data_q, buf_data_d;
    logic [SEL_W-1:0]    buf_sel_q, buf_sel_d;
    logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;
    logic [NCH-1:0]      out_valid_q, out_valid_d;

    logic                rr_found;
    logic [SEL_W-1:0]    rr_tgt;
    logic [SEL_W-1:0]    rr_idx;
    logic                drain;
    logic                accept;
    logic                hit;
    logic                load;
    logic                drop;
    logic [SEL_W-1:0]    tgt;

    // First enabled channel at or after rr_ptr, wrapping modulo 4
    always_comb begin
        rr_found = 1'b0;
        rr_tgt   = rr_ptr_q;
        rr_idx   = rr_ptr_q;
        for (int i = 0; i < int'(NCH); i++) begin
            rr_idx = SEL_W'(rr_ptr_q + SEL_W'(i));
            if (!rr_found && en_mask[rr_idx]) begin
                rr_found = 1'b1;
                rr_tgt   = rr_idx;
            end
        end
    end

    // Handshake, target resolution and next-state
    always_comb begin
        state_d     = state_q;
        buf_data_d  = buf_data_q;
        buf_sel_d   = buf_sel_q;
        rr_ptr_d    = rr_ptr_q;
        drop_cnt_d  = drop_cnt_q;
        out_valid_d = '0;

        drain    = (state_q == S_FULL) && out_ready[buf_sel_q];
        in_ready = (state_q == S_EMPTY) || out_ready[buf_sel_q];
        accept   = in_valid && in_ready;
        tgt      = mode ? rr_tgt : in_dest;
        hit      = mode ? rr_found : en_mask[in_dest];
        load     = accept && hit;
        drop     = accept && !hit;

        case (state_q)
            S_EMPTY: if (load) state_d = S_FULL;
            S_FULL: begin
                if (load)       state_d = S_FULL;
                else if (drain) state_d = S_EMPTY;
            end
            default: state_d = S_EMPTY;
        endcase

        if (load) begin
            buf_data_d = in_data;
            buf_sel_d  = tgt;
            if (mode) rr_ptr_d = SEL_W'(tgt + SEL_W'(1));
        end

        if (drop && (drop_cnt_q != {CNT_W{1'b1}})) begin
            drop_cnt_d = CNT_W'(drop_cnt_q + CNT_W'(1));
        end

        if (state_d == S_FULL) begin
            out_valid_d = NCH'(NCH'(1) << buf_sel_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_EMPTY;
            buf_data_q  <= '0;
            buf_sel_q   <= '0;
            rr_ptr_q    <= '0;
            drop_cnt_q  <= '0;
            out_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            buf_data_q  <= buf_data_d;
            buf_sel_q   <= buf_sel_d;
            rr_ptr_q    <= rr_ptr_d;
            drop_cnt_q  <= drop_cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = buf_data_q;
    assign drop_cnt  = drop_cnt_q;
    assign busy      = (state_q == S_FULL);

endmodule
